// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, register address width, result-select encodings.
// No logic; types and constants only.
// Imported by every writeback-stage file.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RESULT_ALU  = 2'b00,
        RESULT_MEM  = 2'b01,
        RESULT_PC4  = 2'b10,
        RESULT_RSVD = 2'b11
    } result_src_e;
endpackage

// File: rtl/regfile32.sv
// Integer register file: one synchronous write port, two asynchronous read ports, x0 hardwired to 0.
// Write visible one cycle after the commit edge; reads are 0-cycle combinational.
// No backpressure: a write is taken whenever we is high on the edge.
module regfile32
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREGS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN_P-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN_P-1:0]     rdata1,
    output logic [XLEN_P-1:0]     rdata2
);
    logic [XLEN_P-1:0] regs_q [NREGS];
    logic [XLEN_P-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0) && (int'(waddr) < NREGS)) begin
            regs_d[waddr] = wdata;
        end
        // Entry 0 is never stored so a write to x0 cannot leak into reads.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if ((raddr1 != '0) && (int'(raddr1) < NREGS)) rdata1 = regs_q[raddr1];
        if ((raddr2 != '0) && (int'(raddr2) < NREGS)) rdata2 = regs_q[raddr2];
    end
endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, register commit, decode read ports, retired-writeback counter.
// Commit/counter latency 1 cycle; wbResult/wbValid/reads combinational (WB_BYPASS_EN adds write-through).
// No backpressure: we low stalls the stage (no commit, no count).
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREGS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [XLEN_P-1:0]     aluResult,
    input  logic [XLEN_P-1:0]     memoryRes,
    input  logic [XLEN_P-1:0]     pcPlus4,
    input  logic [REG_ADDR_W-1:0] rdAddr,
    input  logic                  RegWrite,
    input  logic [1:0]            ResultSrc,
    input  logic [REG_ADDR_W-1:0] rs1Addr,
    input  logic [REG_ADDR_W-1:0] rs2Addr,
    output logic [XLEN_P-1:0]     rs1Data,
    output logic [XLEN_P-1:0]     rs2Data,
    output logic [XLEN_P-1:0]     wbResult,
    output logic                  wbValid,
    output logic [31:0]           retireCount
);
    logic [XLEN_P-1:0] rf_rd1;
    logic [XLEN_P-1:0] rf_rd2;
    logic [31:0]       retire_count_q;
    logic [31:0]       retire_count_d;

    always_comb begin
        case (result_src_e'(ResultSrc))
            RESULT_MEM: wbResult = memoryRes;
            RESULT_PC4: wbResult = pcPlus4;
            default:    wbResult = aluResult;
        endcase
    end

    assign wbValid = we && RegWrite && (rdAddr != '0);

    regfile32 #(
        .XLEN_P (XLEN_P),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wbValid),
        .waddr  (rdAddr),
        .wdata  (wbResult),
        .raddr1 (rs1Addr),
        .raddr2 (rs2Addr),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

`ifdef WB_BYPASS_EN
    // wbValid already excludes x0, so the x0-reads-zero rule survives the bypass.
    always_comb begin
        rs1Data = (wbValid && (rs1Addr == rdAddr)) ? wbResult : rf_rd1;
        rs2Data = (wbValid && (rs2Addr == rdAddr)) ? wbResult : rf_rd2;
    end
`else
    always_comb begin
        rs1Data = rf_rd1;
        rs2Data = rf_rd2;
    end
`endif

    always_comb begin
        retire_count_d = retire_count_q;
        if (we) retire_count_d = retire_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) retire_count_q <= '0;
        else       retire_count_q <= retire_count_d;
    end

    assign retireCount = retire_count_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile; expected values come from a reference model and a scoreboard queue.
module tb_writeback_regfile;
    logic        clk = 1'b0;
    logic        reset, we, RegWrite;
    logic [31:0] aluResult, memoryRes, pcPlus4;
    logic [4:0]  rdAddr, rs1Addr, rs2Addr;
    logic [1:0]  ResultSrc;
    logic [31:0] rs1Data, rs2Data, wbResult, retireCount;
    logic        wbValid;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_rf [32];
    logic [31:0] model_cnt = 32'd0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    writeback_regfile dut (
        .clk(clk), .reset(reset), .we(we), .aluResult(aluResult), .memoryRes(memoryRes),
        .pcPlus4(pcPlus4), .rdAddr(rdAddr), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .wbResult(wbResult), .wbValid(wbValid), .retireCount(retireCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_result();
        if (ResultSrc == 2'b01)      return memoryRes;
        else if (ResultSrc == 2'b10) return pcPlus4;
        else                         return aluResult;
    endfunction

    function automatic logic model_valid();
        return we && RegWrite && (rdAddr != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (model_valid() && a == rdAddr) return model_result();
`endif
        return model_rf[a];
    endfunction

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
            model_cnt = 32'd0;
        end else if (we) begin
            model_cnt = model_cnt + 32'd1;
            if (RegWrite && rdAddr != 5'd0) model_rf[rdAddr] = model_result();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; we = 0; RegWrite = 0; ResultSrc = 2'b00;
        aluResult = 0; memoryRes = 0; pcPlus4 = 0; rdAddr = 0; rs1Addr = 0; rs2Addr = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; we = 1; RegWrite = 1; rdAddr = 5'd3; aluResult = 32'hFFFF_0003;
        tick();
        tick();
        idle();
        for (int r = 1; r < 32; r++) begin
            rs1Addr = 5'(r); rs2Addr = 5'(32 - r);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            #1;
            exp = exp_q.pop_front(); n_tests++;
            if (rs1Data !== exp) begin n_fail++; $display("FAIL reset_rs1 x%0d got %h want %h", r, rs1Data, exp); end
            exp = exp_q.pop_front(); n_tests++;
            if (rs2Data !== exp) begin n_fail++; $display("FAIL reset_rs2 x%0d got %h want %h", 32 - r, rs2Data, exp); end
        end
        n_tests++;
        if (retireCount !== 32'd0) begin n_fail++; $display("FAIL reset_count got %h want 0", retireCount); end
    endtask

    task automatic test_result_select();
        logic [1:0]  srcs [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [4:0]  rds  [4] = '{5'd5, 5'd1, 5'd9, 5'd31};
        logic [31:0] want [4] = '{32'hDEAD_BEEF, 32'h0000_0104, 32'hA5A5_0011, 32'hA5A5_0011};
        for (int k = 0; k < 4; k++) begin
            idle();
            we = 1; RegWrite = 1; rdAddr = rds[k]; ResultSrc = srcs[k];
            aluResult = 32'hA5A5_0011; memoryRes = 32'hDEAD_BEEF; pcPlus4 = 32'h0000_0104;
            exp_q.push_back(want[k]);
            #1;
            n_tests++;
            if (wbResult !== want[k] || wbValid !== 1'b1) begin
                n_fail++; $display("FAIL select_src%0d got %h/%b want %h/1", k, wbResult, wbValid, want[k]);
            end
            tick();
            idle();
            rs1Addr = rds[k];
            #1;
            exp = exp_q.pop_front(); n_tests++;
            if (rs1Data !== exp) begin n_fail++; $display("FAIL commit_x%0d got %h want %h", rds[k], rs1Data, exp); end
        end
    endtask

    task automatic test_x0();
        idle();
        we = 1; RegWrite = 1; rdAddr = 5'd0; aluResult = 32'h0000_1234; rs2Addr = 5'd0;
        #1;
        n_tests++;
        if (wbValid !== 1'b0 || rs2Data !== 32'd0) begin
            n_fail++; $display("FAIL x0_same_cycle got valid=%b data=%h want 0/0", wbValid, rs2Data);
        end
        tick();
        RegWrite = 0;
        #1;
        n_tests++;
        if (rs2Data !== 32'd0) begin n_fail++; $display("FAIL x0_after got %h want 0", rs2Data); end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; RegWrite = 1; rdAddr = 5'd7; aluResult = 32'h0000_0011;
        tick();
        aluResult = 32'h0000_0055; rs1Addr = 5'd7; rs2Addr = 5'd7;
`ifdef WB_BYPASS_EN
        exp_q.push_back(32'h0000_0055);
`else
        exp_q.push_back(32'h0000_0011);
`endif
        #1;
        exp = exp_q.pop_front(); n_tests++;
        if (rs1Data !== exp || rs2Data !== exp) begin
            n_fail++; $display("FAIL same_cycle_x7 got %h/%h want %h", rs1Data, rs2Data, exp);
        end
        tick();
        we = 0; aluResult = 32'h0000_0099;
        #1;
        n_tests++;
        if (rs1Data !== 32'h0000_0055) begin n_fail++; $display("FAIL stalled_no_bypass got %h want 00000055", rs1Data); end
        tick();
    endtask

    task automatic test_stall_and_reset();
        logic [31:0] cnt_before;
        idle();
        we = 1; RegWrite = 1; rdAddr = 5'd3; aluResult = 32'h0000_0777;
        tick();
        we = 0; aluResult = 32'h0000_0ABC; rs1Addr = 5'd3;
        cnt_before = model_cnt;
        tick();
        #1;
        n_tests++;
        if (rs1Data !== 32'h0000_0777) begin n_fail++; $display("FAIL stall_x3 got %h want 00000777", rs1Data); end
        n_tests++;
        if (retireCount !== cnt_before) begin n_fail++; $display("FAIL stall_count got %h want %h", retireCount, cnt_before); end
        reset = 1; we = 1;
        tick();
        reset = 0; we = 0;
        #1;
        n_tests++;
        if (rs1Data !== 32'd0 || retireCount !== 32'd0) begin
            n_fail++; $display("FAIL reset_wins got x3=%h cnt=%h want 0/0", rs1Data, retireCount);
        end
        we = 1; RegWrite = 0;
        tick(); tick(); tick();
        n_tests++;
        if (retireCount !== 32'd3) begin n_fail++; $display("FAIL count_no_regwrite got %h want 3", retireCount); end
    endtask

    task automatic test_wrap();
        idle();
        @(negedge clk);
        force dut.retire_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_count_q;
        model_cnt = 32'hFFFF_FFFE;
        #1;
        n_tests++;
        if (retireCount !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL preload got %h want fffffffe", retireCount); end
        we = 1;
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0000_0000);
        for (int k = 0; k < 2; k++) begin
            tick();
            exp = exp_q.pop_front(); n_tests++;
            if (retireCount !== exp) begin n_fail++; $display("FAIL wrap_step%0d got %h want %h", k, retireCount, exp); end
        end
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 80; c++) begin
            we = ($urandom_range(0, 3) != 0); RegWrite = $urandom_range(0, 1) == 1;
            rdAddr = 5'($urandom_range(0, 31)); ResultSrc = 2'($urandom_range(0, 3));
            aluResult = $urandom; memoryRes = $urandom; pcPlus4 = $urandom;
            rs1Addr = (c % 3 == 0) ? rdAddr : 5'($urandom_range(0, 31));
            rs2Addr = 5'($urandom_range(0, 31));
            exp_q.push_back(model_read(rs1Addr)); exp_q.push_back(model_read(rs2Addr));
            #1;
            exp = exp_q.pop_front(); n_tests++;
            if (rs1Data !== exp) begin n_fail++; $display("FAIL rand_rs1 c%0d got %h want %h", c, rs1Data, exp); end
            exp = exp_q.pop_front(); n_tests++;
            if (rs2Data !== exp) begin n_fail++; $display("FAIL rand_rs2 c%0d got %h want %h", c, rs2Data, exp); end
            n_tests++;
            if (wbResult !== model_result() || wbValid !== model_valid()) begin
                n_fail++; $display("FAIL rand_wb c%0d got %h/%b want %h/%b", c, wbResult, wbValid, model_result(), model_valid());
            end
            tick();
            n_tests++;
            if (retireCount !== model_cnt) begin n_fail++; $display("FAIL rand_count c%0d got %h want %h", c, retireCount, model_cnt); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        idle();
        #2;
        test_reset();
        test_result_select();
        test_x0();
        test_bypass();
        test_stall_and_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback-stage consumer of the MEM/WB pipeline bank outputs in the pipelined RISC-V core. Selects the final result (ALU, load data, or PC+4) from ResultSrc, commits it to the 32×32 integer register file, serves the two decode-stage read ports, and keeps a retired-writeback counter. Sits between the MEM/WB bank and the decode stage; the selected result is also exported for the forwarding unit.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, architectural register count (address width fixed at 5)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  writeback stage enable (low = stage stalled, no commit, no count)
- aluResult  in  XLEN  ALU result from MEM/WB bank
- memoryRes  in  XLEN  load data from MEM/WB bank
- pcPlus4  in  XLEN  link value from MEM/WB bank
- rdAddr  in  5  destination register
- RegWrite  in  1  commit request
- ResultSrc  in  2  result select
- rs1Addr, rs2Addr  in  5 each  decode-stage read addresses
- rs1Data, rs2Data  out  XLEN each  read data, combinational
- wbResult  out  XLEN  selected result, combinational, to forwarding unit
- wbValid  out  1  we && RegWrite && rdAddr != 0, combinational
- retireCount  out  32  registered count of enabled writeback cycles

## Operation
- Result select: ResultSrc 00 → aluResult; 01 → memoryRes; 10 → pcPlus4; 11 → aluResult (reserved, no error).
- Commit: on rising clk, if !reset && we && RegWrite && rdAddr != 0, register[rdAddr] ← wbResult.
- x0: never written; reads of address 0 always return 0, including during a write targeting 0.
- Reads: rsNData = register[rsNAddr], asynchronous, subject to bypass (see Configuration).
- retireCount: +1 on each rising clk with !reset && we; wraps 0xFFFF_FFFF → 0. Not gated by RegWrite (stores and branches count as well).
- Reset: all registers x1–x31 cleared to 0; retireCount cleared to 0; any commit presented that cycle is dropped (reset wins over we).
- we low: register file and counter hold; combinational outputs still track inputs.

## Timing
- Write latency: 1 cycle; committed value visible at read ports from the cycle after the commit edge (or in the same cycle with bypass).
- Read latency: 0 cycles (combinational from rsNAddr).
- wbResult / wbValid: 0-cycle combinational from MEM/WB inputs.
- retireCount: registered; value after edge N reflects enabled cycles up to and including N.
- Reset outputs: rs1Data = rs2Data = 0 for every address the cycle after reset; retireCount = 0; wbResult/wbValid follow inputs (no reset value, combinational).
- Both read ports may address the same register or rdAddr concurrently; no arbitration required.

## Configuration
- WB_BYPASS_EN defined: if wbValid && rsNAddr == rdAddr, rsNData = wbResult in the same cycle (write-through); removes the decode/writeback structural hazard.
- WB_BYPASS_EN undefined: rsNData always returns the stored value; a same-cycle read of rdAddr returns the old contents and the hazard unit must stall one cycle.
- x0 rule holds in both builds.

## Structure
- Shared package riscv_pkg: XLEN, REG_ADDR_W = 5, ResultSrc encodings RESULT_ALU = 2'b00, RESULT_MEM = 2'b01, RESULT_PC4 = 2'b10.
- One sub-module: regfile32 (storage, one write port, two async read ports, x0 hardwiring). Result mux, bypass and counter stay in the top.

## Test plan
- Reset then read x1..x31 → all 0; retireCount = 0.
- we=1, RegWrite=1, rdAddr=5, ResultSrc=01, memoryRes=0xDEAD_BEEF; next cycle rs1Addr=5 → rs1Data=0xDEAD_BEEF; ResultSrc=10, pcPlus4=0x104, rdAddr=1 → x1=0x104.
- Write rdAddr=0 with aluResult=0x1234 → rs2Addr=0 reads 0 same cycle and after.
- Same-cycle read of rdAddr=7 during write of 0x55: with WB_BYPASS_EN → 0x55; without → previous x7 value, 0x55 next cycle.
- we=0 with RegWrite=1, rdAddr=3 → x3 unchanged, retireCount unchanged; reset asserted with valid commit to x3 → x3 = 0.
- Preload retireCount to 0xFFFF_FFFE via 0xFFFF_FFFE enabled cycles (or force) → two more enabled cycles give 0xFFFF_FFFF then 0.
